// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// Transforms LANES columns of the latched 128-bit state per clock, with a valid/ready handshake on each side.
module mix_columns_seq #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("mix_columns_seq: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    localparam logic [2:0] LANE_STEP = 3'(LANES);

    state_t           state, state_next;
    logic [1:0]       col;
    logic             mode;
    logic [0:3][31:0] work;
    logic [0:3][31:0] work_step;
    logic             load, step, last;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return xt(b);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return xt(b) ^ b;
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // Row indices are 2-bit so r+1..r+3 wrap modulo 4 naturally.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [0:3][7:0] a;
        logic [0:3][7:0] b;
        logic [1:0]      r;
        a = c;
        b = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            r = 2'(i);
            if (inv)
                b[r] = gm14(a[r]) ^ gm11(a[r + 2'd1]) ^ gm13(a[r + 2'd2]) ^ gm9(a[r + 2'd3]);
            else
                b[r] = gm2(a[r]) ^ gm3(a[r + 2'd1]) ^ a[r + 2'd2] ^ a[r + 2'd3];
        end
        return b;
    endfunction

    always_comb begin
        logic [1:0] idx;
        work_step = work;
        idx       = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            idx            = col + 2'(l);
            work_step[idx] = mix_col(work[idx], mode);
        end
    end

    assign last = (({1'b0, col} + LANE_STEP) == 3'd4);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = PROC;
                end
            end
            PROC: begin
                step = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                // Downstream acceptance frees the engine in the same cycle.
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load       = 1'b1;
                        state_next = PROC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            mode  <= 1'b0;
            work  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                work <= in_state;
                mode <= in_inv;
                col  <= '0;
            end else if (step) begin
                work <= work_step;
                col  <= col + LANE_STEP[1:0];
            end
        end
    end

    assign out_valid = (state == DONE);
    assign busy      = (state == PROC);
    assign out_state = work;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: LANES=1,2,4 instances, each with its own driver and scoreboard monitor
// checked against a byte-level GF(2^8) matrix model.
module tb_mix_columns_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    function automatic logic [7:0] gmul(input logic [7:0] x, input int m);
        int p;
        int xv;
        p  = 0;
        xv = int'(x);
        for (int i = 0; i < 8; i++) begin
            if (((m >> i) & 1) != 0) p = p ^ xv;
            xv = xv << 1;
            if ((xv & 'h100) != 0) xv = xv ^ 'h11b;
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        int fw[4];
        int iv[4];
        logic [7:0] a[16];
        logic [7:0] acc;
        logic [127:0] res;
        fw = '{2, 3, 1, 1};
        iv = '{14, 11, 13, 9};
        for (int k = 0; k < 16; k++) a[k] = s[127 - 8 * k -: 8];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(a[4 * c + (r + j) % 4], inv ? iv[j] : fw[j]);
                res[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input int lanes, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s LANES=%0d actual=%h required=%h t=%0t", name, lanes, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name, input int lanes);
        n_cmp++;
        n_err++;
        $display("FAIL %s LANES=%0d actual=timeout required=event t=%0t", name, lanes, $time);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int L   = 1 << g;
        localparam int LAT = 4 / L;

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic         in_inv;
        logic [127:0] in_state;
        logic         out_valid;
        logic         out_ready;
        logic [127:0] out_state;
        logic         busy;
        logic [127:0] exp_q[$];

        mix_columns_seq #(.LANES(L)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_inv   (in_inv),
            .in_state (in_state),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_state(out_state),
            .busy     (busy)
        );

        always @(negedge clk) begin
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) timeout_fail("unexpected_output", L);
                else chk("result", L, out_state, exp_q.pop_front());
            end
        end

        task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] exp,
                            input bit keep, output int n);
            bit hs;
            in_state = s;
            in_inv   = inv;
            in_valid = 1'b1;
            n        = 0;
            hs       = 1'b0;
            while (!hs && n < 100) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!hs) timeout_fail("input_handshake", L);
            else exp_q.push_back(exp);
            if (!keep) in_valid = 1'b0;
        endtask

        task automatic wait_valid(output int n);
            n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (!out_valid) timeout_fail("wait_out_valid", L);
        endtask

        task automatic drain();
            int n;
            n = 0;
            while ((exp_q.size() != 0 || out_valid) && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 100) timeout_fail("drain", L);
        endtask

        initial begin
            logic [127:0] vin[3];
            logic [127:0] vout[3];
            logic         vinv[3];
            logic [127:0] s;
            logic [127:0] held;
            logic         inv;
            int           n;

            vin[0] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
            vout[0] = 128'h046681e5e0cb199a48f8d37a2806264c; vinv[0] = 1'b0;
            vin[1] = 128'h046681e5e0cb199a48f8d37a2806264c;
            vout[1] = 128'hd4bf5d30e0b452aeb84111f11e2798e5; vinv[1] = 1'b1;
            vin[2] = 128'hdb135345f20a225c010101012d26314c;
            vout[2] = 128'h8e4da1bc9fdc589d010101014d7ebdf8; vinv[2] = 1'b0;

            rst_n     = 1'b0;
            in_valid  = 1'b0;
            in_inv    = 1'b0;
            in_state  = '0;
            out_ready = 1'b1;
            #2;
            chk("reset_in_ready", L, 128'(in_ready), 128'd1);
            chk("reset_out_valid", L, 128'(out_valid), 128'd0);
            chk("reset_busy", L, 128'(busy), 128'd0);
            chk("reset_out_state", L, out_state, 128'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;

            for (int i = 0; i < 3; i++) begin
                send(vin[i], vinv[i], vout[i], 1'b0, n);
                wait_valid(n);
                chk("latency", L, 128'(n), 128'(LAT));
                drain();
            end

            for (int i = 0; i < 24; i++) begin
                s   = {$urandom, $urandom, $urandom, $urandom};
                inv = 1'($urandom_range(0, 1));
                send(s, inv, ref_mix(s, inv), 1'b0, n);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drain();

            send(vin[2], 1'b0, vout[2], 1'b0, n);
            wait_valid(n);
            out_ready = 1'b0;
            held = out_state;
            repeat (5) begin
                @(negedge clk);
                chk("bp_out_valid", L, 128'(out_valid), 128'd1);
                chk("bp_out_state", L, out_state, held);
                chk("bp_in_ready", L, 128'(in_ready), 128'd0);
                @(posedge clk);
                #1;
            end
            s         = {$urandom, $urandom, $urandom, $urandom};
            in_state  = s;
            in_inv    = 1'b1;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            chk("bypass_in_ready", L, 128'(in_ready), 128'd1);
            @(posedge clk);
            #1;
            exp_q.push_back(ref_mix(s, 1'b1));
            in_valid = 1'b0;
            chk("bypass_out_valid", L, 128'(out_valid), 128'd0);
            chk("bypass_busy", L, 128'(busy), 128'd1);
            wait_valid(n);
            chk("bypass_latency", L, 128'(n), 128'(LAT));
            drain();

            for (int i = 0; i < 6; i++) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                send(s, 1'(i), ref_mix(s, 1'(i)), 1'b1, n);
                if (i > 0) chk("stream_period", L, 128'(n), 128'(LAT + 1));
            end
            in_valid = 1'b0;
            drain();

            s = {$urandom, $urandom, $urandom, $urandom};
            send(s, 1'b0, ref_mix(s, 1'b0), 1'b0, n);
            repeat ((LAT > 1) ? 1 : 0) begin
                @(posedge clk);
                #1;
            end
            chk("busy_in_proc", L, 128'(busy), 128'd1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("async_rst_out_valid", L, 128'(out_valid), 128'd0);
            chk("async_rst_busy", L, 128'(busy), 128'd0);
            chk("async_rst_out_state", L, out_state, 128'd0);
            chk("async_rst_in_ready", L, 128'(in_ready), 128'd1);
            exp_q.delete();
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            send(vin[1], 1'b1, vout[1], 1'b0, n);
            wait_valid(n);
            chk("post_rst_latency", L, 128'(n), 128'(LAT));
            drain();

            chk("queue_empty", L, 128'(exp_q.size()), 128'd0);
            n_done++;
        end
    end

    initial begin
        wait (n_done == 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=not_finished required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
